// File: rtl/timer_seq.sv
`default_nettype none
// ============================================================================
// Module   : timer_seq
// Function : Round sequencer for a 5-bit interval timer (arm, run, pause,
//            expiry detect, near-expiry warning, saturating round tally).
// Revision : 1.0
// ============================================================================
module timer_seq #(
    parameter int WARN_MARGIN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [4:0] limit,
    input  logic [4:0] tmout,
    output logic [1:0] tctrl,
    output logic [1:0] state,
    output logic       expired,
    output logic       warn,
    output logic [7:0] rounds
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] C_CTRL_HOLD  = 2'b00;
    localparam logic [1:0] C_CTRL_CLEAR = 2'b01;
    localparam logic [1:0] C_CTRL_COUNT = 2'b10;
    localparam logic [5:0] C_WARN_MARGIN = 6'(WARN_MARGIN);
    localparam logic [7:0] C_ROUNDS_MAX  = 8'hFF;

    state_t     r_state;
    logic [4:0] r_lim_q;
    logic [1:0] r_tctrl;
    logic       r_expired;
    logic       r_warn;
    logic [7:0] r_rounds;

    state_t     w_state_nxt;
    logic [4:0] w_lim_nxt;
    logic       w_fire;
    logic [1:0] w_tctrl_nxt;
    logic [5:0] w_remain;
    logic       w_active_nxt;
    logic       w_warn_nxt;

    // Priority: stop > expiry > pause > start.
    always_comb begin
        w_state_nxt = r_state;
        w_lim_nxt   = r_lim_q;
        w_fire      = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (limit != 5'd0)) begin
                        w_state_nxt = S_RUN;
                        w_lim_nxt   = limit;
                    end
                end
                S_RUN: begin
                    if (tmout >= r_lim_q) begin
                        w_state_nxt = S_DONE;
                        w_fire      = 1'b1;
                    end else if (pause) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pause || start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Timer control follows the next state so it lines up with `state`.
    always_comb begin
        case (w_state_nxt)
            S_IDLE:  w_tctrl_nxt = C_CTRL_CLEAR;
            S_RUN:   w_tctrl_nxt = C_CTRL_COUNT;
            S_PAUSE: w_tctrl_nxt = C_CTRL_HOLD;
            S_DONE:  w_tctrl_nxt = C_CTRL_HOLD;
            default: w_tctrl_nxt = C_CTRL_CLEAR;
        endcase
    end

    always_comb begin
        w_remain     = {1'b0, w_lim_nxt} - {1'b0, tmout};
        w_active_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
        w_warn_nxt   = w_active_nxt && (tmout < w_lim_nxt) && (w_remain <= C_WARN_MARGIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lim_q   <= 5'd0;
            r_tctrl   <= C_CTRL_CLEAR;
            r_expired <= 1'b0;
            r_warn    <= 1'b0;
            r_rounds  <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_lim_q   <= w_lim_nxt;
            r_tctrl   <= w_tctrl_nxt;
            r_expired <= w_fire;
            r_warn    <= w_warn_nxt;
            if (w_fire && (r_rounds != C_ROUNDS_MAX)) begin
                r_rounds <= r_rounds + 8'd1;
            end
        end
    end

    assign state   = r_state;
    assign tctrl   = r_tctrl;
    assign expired = r_expired;
    assign warn    = r_warn;
    assign rounds  = r_rounds;

endmodule
`default_nettype wire

// File: tb/tb_timer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_seq
// Function : Directed self-checking bench for timer_seq with a behavioural
//            12-clock-tick interval timer closing the loop.
// Revision : 1.0
// ============================================================================
module tb_timer_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       stop;
    logic [4:0] limit;
    logic [4:0] tmout;
    logic [1:0] tctrl;
    logic [1:0] state;
    logic       expired;
    logic       warn;
    logic [7:0] rounds;

    int n_total = 0;
    int n_bad   = 0;

    timer_seq #(.WARN_MARGIN(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .stop    (stop),
        .limit   (limit),
        .tmout   (tmout),
        .tctrl   (tctrl),
        .state   (state),
        .expired (expired),
        .warn    (warn),
        .rounds  (rounds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Interval timer: 01 clears, 10 counts one tick per 12 clocks, 00 holds.
    logic [3:0] tm_pre;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tmout  <= 5'd0;
            tm_pre <= 4'd0;
        end else begin
            case (tctrl)
                2'b01: begin
                    tmout  <= 5'd0;
                    tm_pre <= 4'd0;
                end
                2'b10: begin
                    if (tm_pre == 4'd11) begin
                        tm_pre <= 4'd0;
                        tmout  <= tmout + 5'd1;
                    end else begin
                        tm_pre <= tm_pre + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Steps n cycles, reporting the cycle index (k0-relative) of the first
    // expired pulse and how many pulses were seen.
    task automatic watch(input int k0, input int n, output int first, output int npulse);
        first  = -1;
        npulse = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (expired) begin
                npulse++;
                if (first < 0) first = k0 + i;
            end
        end
    endtask

    int f, np, r_before;

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; limit = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_state", state, 0);
        check_val("rst_tctrl", tctrl, 1);
        check_val("rst_expired", expired, 0);
        check_val("rst_warn", warn, 0);
        check_val("rst_rounds", rounds, 0);

        // Zero limit is ignored.
        limit = 5'd0;
        pulse_start();
        check_val("zero_state", state, 0);
        check_val("zero_tctrl", tctrl, 1);
        check_val("zero_expired", expired, 0);

        // Basic round, limit 3; mid-round limit change must be ignored.
        step();
        limit = 5'd3;
        pulse_start();
        limit = 5'd7;
        check_val("basic_state_run", state, 1);
        check_val("basic_tctrl_run", tctrl, 2);
        watch(0, 40, f, np);
        check_val("basic_exp_cycle", f, 37);
        check_val("basic_exp_count", np, 1);
        check_val("basic_state_done", state, 3);
        check_val("basic_tctrl_done", tctrl, 0);
        check_val("basic_tmout_hold", tmout, 3);
        check_val("basic_rounds", rounds, 1);
        check_val("basic_warn_done", warn, 0);
        pulse_start();
        check_val("ack_state", state, 0);
        check_val("ack_tctrl", tctrl, 1);

        // Pause at S+10, resume at S+15, limit 2.
        step();
        limit = 5'd2;
        pulse_start();
        repeat (9) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        check_val("pause_state", state, 2);
        check_val("pause_tctrl_s10", tctrl, 0);
        repeat (4) step();
        check_val("pause_tctrl_s14", tctrl, 0);
        check_val("pause_tmout_frozen", tmout, 0);
        pulse_start();
        check_val("resume_state", state, 1);
        watch(15, 18, f, np);
        check_val("pause_exp_cycle", f, 30);
        check_val("pause_exp_count", np, 1);
        check_val("pause_tmout_end", tmout, 2);
        check_val("pause_rounds", rounds, 2);
        pulse_start();

        // Abort at S+20, limit 4.
        step();
        limit = 5'd4;
        pulse_start();
        repeat (19) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("abort_state", state, 0);
        check_val("abort_tctrl", tctrl, 1);
        step();
        step();
        check_val("abort_tmout_clr", tmout, 0);
        watch(22, 40, f, np);
        check_val("abort_no_exp", np, 0);
        check_val("abort_rounds", rounds, 2);

        // Collision A: pause on the expiry cycle (limit 1 expires at S+13).
        limit = 5'd1;
        pulse_start();
        repeat (12) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        check_val("collA_state", state, 3);
        check_val("collA_expired", expired, 1);
        check_val("collA_rounds", rounds, 3);
        step();
        check_val("collA_exp_once", expired, 0);
        pulse_start();

        // Collision B: stop on the expiry cycle.
        step();
        r_before = rounds;
        pulse_start();
        repeat (12) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("collB_state", state, 0);
        check_val("collB_expired", expired, 0);
        check_val("collB_rounds", rounds, r_before);
        watch(13, 5, f, np);
        check_val("collB_no_exp", np, 0);

        // Collision C: stop and start together in IDLE.
        limit = 5'd5;
        stop = 1'b1;
        start = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b0;
        check_val("collC_state", state, 0);
        check_val("collC_tctrl", tctrl, 1);

        // Warn with limit 5, margin 3: rises at S+25, falls at S+61 (DONE).
        step();
        limit = 5'd5;
        pulse_start();
        repeat (23) step();
        check_val("warn_s23", warn, 0);
        step();
        check_val("warn_s24", warn, 0);
        step();
        check_val("warn_s25", warn, 1);
        repeat (35) step();
        check_val("warn_s60", warn, 1);
        step();
        check_val("warn_s61", warn, 0);
        check_val("warn_s61_state", state, 3);
        check_val("warn_rounds", rounds, 4);
        pulse_start();

        // 256 more limit-1 rounds: rounds must saturate at 255.
        limit = 5'd1;
        for (int i = 0; i < 256; i++) begin
            pulse_start();
            repeat (13) step();
            pulse_start();
            if (i == 249) check_val("sat_254", rounds, 254);
        end
        check_val("sat_255", rounds, 255);
        check_val("sat_state", state, 0);

        // Asynchronous reset mid-round.
        limit = 5'd3;
        pulse_start();
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_val("arst_state", state, 0);
        check_val("arst_tctrl", tctrl, 1);
        check_val("arst_rounds", rounds, 0);
        check_val("arst_warn", warn, 0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
